// File: rtl/libhdl_fifo_wr_arb.sv
// Burst-locked round-robin arbiter that shares one FIFO write port
// among N_REQ valid/ready requesters.
module libhdl_fifo_wr_arb #(
    parameter int N_REQ     = 4,
    parameter int DATA_LEN  = 32,
    parameter int MAX_BURST = 16,
    localparam int IDX_LEN  = $clog2(N_REQ)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_REQ-1:0]          i_vld,
    input  logic [N_REQ*DATA_LEN-1:0] i_dat,
    input  logic [N_REQ-1:0]          i_last,
    output logic [N_REQ-1:0]          o_rdy,
    output logic                      o_wvld,
    output logic [DATA_LEN-1:0]       o_wdat,
    input  logic                      i_wrdy,
    output logic                      o_gnt_vld,
    output logic [IDX_LEN-1:0]        o_gnt_idx
);

    localparam int CNT_LEN = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [CNT_LEN-1:0] CNT_LAST =
        CNT_LEN'((MAX_BURST == 0) ? 0 : MAX_BURST - 1);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t               state;
    logic [IDX_LEN-1:0]   gnt_idx;
    logic [IDX_LEN-1:0]   rr_ptr;
    logic [CNT_LEN-1:0]   beat_cnt;
    logic [IDX_LEN-1:0]   pick;
    logic                 lock;
    logic                 sel_vld;
    logic                 sel_last;
    logic                 hs;
    logic                 cnt_full;
    logic                 burst_end;

    // Search rr_ptr+1 .. rr_ptr+N_REQ; scanning backwards lets the
    // nearest candidate overwrite farther ones.
    function automatic logic [IDX_LEN-1:0] rr_pick(
        input logic [N_REQ-1:0]   vld,
        input logic [IDX_LEN-1:0] ptr
    );
        logic [IDX_LEN-1:0] sel;
        int                 c;
        sel = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            c = (int'(ptr) + i) % N_REQ;
            if (vld[IDX_LEN'(c)]) begin
                sel = IDX_LEN'(c);
            end
        end
        return sel;
    endfunction

    assign pick      = rr_pick(i_vld, rr_ptr);
    assign lock      = (state == LOCK);
    assign sel_vld   = i_vld[gnt_idx];
    assign sel_last  = i_last[gnt_idx];
    assign hs        = lock & sel_vld & i_wrdy;
    assign cnt_full  = (MAX_BURST != 0) && (beat_cnt == CNT_LAST);
    assign burst_end = hs & (sel_last | cnt_full);

    assign o_gnt_vld = lock;
    assign o_gnt_idx = gnt_idx;
    assign o_wvld    = lock & sel_vld;

    always_comb begin
        o_wdat = '0;
        if (o_wvld) begin
            o_wdat = i_dat[int'(gnt_idx) * DATA_LEN +: DATA_LEN];
        end
    end

    always_comb begin
        o_rdy = '0;
        if (lock) begin
            o_rdy[gnt_idx] = i_wrdy;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            gnt_idx  <= '0;
            beat_cnt <= '0;
            rr_ptr   <= IDX_LEN'(N_REQ - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (|i_vld) begin
                        gnt_idx  <= pick;
                        rr_ptr   <= pick;
                        beat_cnt <= '0;
                        state    <= LOCK;
                    end
                end
                LOCK: begin
                    if (burst_end) begin
                        beat_cnt <= '0;
                        state    <= IDLE;
                    end else if (hs && (MAX_BURST != 0)) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_libhdl_fifo_wr_arb.sv
// Directed vector table plus burst and random stream checks
// for the burst-locked write-port arbiter.
module tb_libhdl_fifo_wr_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  vld;
    logic [N-1:0]  last;
    logic          wrdy;
    logic [DW-1:0] dat [N];
    logic [N*DW-1:0] i_dat;
    logic [N-1:0]  o_rdy;
    logic          o_wvld;
    logic [DW-1:0] o_wdat;
    logic          o_gnt_vld;
    logic [1:0]    o_gnt_idx;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign i_dat = {dat[3], dat[2], dat[1], dat[0]};

    libhdl_fifo_wr_arb #(
        .N_REQ(N), .DATA_LEN(DW), .MAX_BURST(MB)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_vld(vld),
        .i_dat(i_dat),
        .i_last(last),
        .o_rdy(o_rdy),
        .o_wvld(o_wvld),
        .o_wdat(o_wdat),
        .i_wrdy(wrdy),
        .o_gnt_vld(o_gnt_vld),
        .o_gnt_idx(o_gnt_idx)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] vld;
        logic [3:0] last;
        logic       wrdy;
        logic [3:0] rdy;
        logic       wvld;
        logic       gv;
        logic [1:0] gi;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [3:0] v,
                                input logic [3:0] l, input logic w,
                                input logic [3:0] rd, input logic wv,
                                input logic g, input logic [1:0] gi);
        vec_t t;
        t.rst = r; t.vld = v; t.last = l; t.wrdy = w;
        t.rdy = rd; t.wvld = wv; t.gv = g; t.gi = gi;
        return t;
    endfunction

    function automatic logic [DW-1:0] tbl_dat(input int k);
        return 32'h1111_1111 * (k + 1);
    endfunction

    // One or more grants of a single requester sending n beats.
    task automatic burst(input int k, input int n, input bit stall);
        int sent = 0, cur = 0, start = 0, nb = 0, gaps = 0, cyc = 0;
        int exp_nb, exp_len;
        bit pg = 1'b0;
        bit done = 1'b0;
        exp_nb = (n + MB - 1) / MB;
        while (!done && cyc < 600) begin
            @(negedge clk);
            cyc++;
            vld  = '0;
            last = '0;
            if (sent < n) begin
                vld[k]  = 1'b1;
                dat[k]  = 32'hC000_0000 + sent;
                last[k] = (sent == n - 1);
            end
            wrdy = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (o_gnt_vld) begin
                if (!pg) start = sent;
                check("burst gnt idx", 64'(o_gnt_idx), 64'(k));
                if (o_rdy[k] && vld[k]) begin
                    check("burst data", 64'(o_wdat), 64'(32'hC000_0000 + sent));
                    sent++;
                    cur++;
                end
            end else begin
                if (pg) begin
                    exp_len = (n - start < MB) ? n - start : MB;
                    check("burst len", 64'(cur), 64'(exp_len));
                    nb++;
                    cur = 0;
                end
                if (sent < n) gaps++;
                else done = 1'b1;
            end
            pg = o_gnt_vld;
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL burst timeout: sent %0d of %0d", sent, n);
        end
        check("burst count", 64'(nb), 64'(exp_nb));
        check("burst idle gaps", 64'(gaps), 64'(exp_nb));
        repeat (2) begin
            @(negedge clk);
            #1;
            check("no extra grant", {62'b0, o_gnt_vld, o_wvld}, 64'b0);
        end
    endtask

    // Random traffic: per-requester sequence numbers, whole bursts,
    // one-hot ready and bounded waiting.
    task automatic random_run(input int cycles);
        int seq [N];
        int waits [N];
        int beats = 0;
        bit hs [N];
        bit prev_gv = 1'b0;
        bit last_ok = 1'b1;
        logic [N-1:0] prev_vld = '0;
        for (int k = 0; k < N; k++) begin
            seq[k] = 0; waits[k] = 0; hs[k] = 1'b0;
        end
        vld = '0;
        last = '0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (hs[k]) begin
                    seq[k]++;
                    vld[k] = 1'b0;
                end
                if (!vld[k] && $urandom_range(0, 2) == 0) begin
                    vld[k]  = 1'b1;
                    last[k] = ($urandom_range(0, 3) == 0);
                    dat[k]  = {8'(k), 24'(seq[k])};
                end
            end
            wrdy = ($urandom_range(0, 3) != 0);
            #1;
            check("rdy onehot", 64'($countones(o_rdy) <= 1), 64'd1);
            if (o_gnt_vld && !prev_gv) begin
                for (int k = 0; k < N; k++) begin
                    if (k == int'(o_gnt_idx)) begin
                        waits[k] = 0;
                    end else if (prev_vld[k]) begin
                        waits[k]++;
                        check("starvation", 64'(waits[k] <= N - 1), 64'd1);
                    end
                end
                beats = 0;
            end
            if (!o_gnt_vld && prev_gv) begin
                check("whole burst", 64'(last_ok), 64'd1);
            end
            for (int k = 0; k < N; k++) begin
                hs[k] = o_rdy[k] && vld[k];
                if (hs[k]) begin
                    check("rand gnt idx", 64'(o_gnt_idx), 64'(k));
                    check("rand data", 64'(o_wdat), 64'({8'(k), 24'(seq[k])}));
                    beats++;
                    check("rand burst max", 64'(beats <= MB), 64'd1);
                    last_ok = last[k] || (beats == MB);
                end
            end
            prev_gv  = o_gnt_vld;
            prev_vld = vld;
        end
    endtask

    vec_t tbl [27];

    initial begin
        tbl[0]  = mk(0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 0);
        tbl[1]  = mk(0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 1, 0);
        tbl[2]  = mk(0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 0);
        tbl[3]  = mk(0, 4'b1111, 4'b1111, 1, 4'b0010, 1, 1, 1);
        tbl[4]  = mk(0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 1);
        tbl[5]  = mk(0, 4'b1111, 4'b1111, 1, 4'b0100, 1, 1, 2);
        tbl[6]  = mk(0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 2);
        tbl[7]  = mk(0, 4'b1111, 4'b1111, 1, 4'b1000, 1, 1, 3);
        tbl[8]  = mk(0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 3);
        tbl[9]  = mk(0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 1, 0);
        tbl[10] = mk(0, 4'b0010, 4'b0000, 1, 4'b0000, 0, 0, 0);
        tbl[11] = mk(0, 4'b0010, 4'b0000, 0, 4'b0000, 1, 1, 1);
        tbl[12] = mk(0, 4'b0010, 4'b0000, 0, 4'b0000, 1, 1, 1);
        tbl[13] = mk(0, 4'b0010, 4'b0010, 1, 4'b0010, 1, 1, 1);
        tbl[14] = mk(0, 4'b1001, 4'b0000, 1, 4'b0000, 0, 0, 1);
        tbl[15] = mk(0, 4'b1001, 4'b0000, 1, 4'b1000, 1, 1, 3);
        tbl[16] = mk(0, 4'b0001, 4'b0000, 1, 4'b1000, 0, 1, 3);
        tbl[17] = mk(0, 4'b1001, 4'b1000, 1, 4'b1000, 1, 1, 3);
        tbl[18] = mk(0, 4'b0001, 4'b0000, 1, 4'b0000, 0, 0, 3);
        tbl[19] = mk(0, 4'b0001, 4'b0000, 1, 4'b0001, 1, 1, 0);
        tbl[20] = mk(1, 4'b0001, 4'b0000, 1, 4'b0001, 1, 1, 0);
        tbl[21] = mk(0, 4'b1100, 4'b0000, 1, 4'b0000, 0, 0, 0);
        tbl[22] = mk(0, 4'b1100, 4'b0100, 1, 4'b0100, 1, 1, 2);
        tbl[23] = mk(0, 4'b1100, 4'b0000, 1, 4'b0000, 0, 0, 2);
        tbl[24] = mk(0, 4'b1000, 4'b1000, 1, 4'b1000, 1, 1, 3);
        tbl[25] = mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 3);
        tbl[26] = mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 3);

        rst  = 1'b1;
        vld  = '0;
        last = '0;
        wrdy = 1'b1;
        for (int k = 0; k < N; k++) dat[k] = tbl_dat(k);
        repeat (3) @(posedge clk);

        for (int i = 0; i < 27; i++) begin
            logic [DW-1:0] exp_dat;
            @(negedge clk);
            rst  = tbl[i].rst;
            vld  = tbl[i].vld;
            last = tbl[i].last;
            wrdy = tbl[i].wrdy;
            #1;
            exp_dat = tbl[i].wvld ? tbl_dat(int'(tbl[i].gi)) : '0;
            check($sformatf("vec %0d", i),
                  {24'b0, o_rdy, o_wvld, o_gnt_vld, o_gnt_idx, o_wdat},
                  {24'b0, tbl[i].rdy, tbl[i].wvld, tbl[i].gv, tbl[i].gi,
                   exp_dat});
        end

        burst(2, 40, 1'b0);
        burst(1, 16, 1'b1);
        burst(0, 5, 1'b1);
        random_run(3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
